instr_mem_sequencer: RTL and testbench

Multicycle sequencer that shares one single-port memory between the core's instruction fetch and its load/store accesses. Each instruction runs FETCH -> DECODE -> optional DATA -> COMMIT: the fetched word is held stable for the core's combinational decode, any data access is performed, and a one-cycle `o_step` pulse then commits the PC update and register write. Sits between the core and the unified memory; adds a watchdog that traps on a memory that never acknowledges.

---
 rtl/instr_mem_sequencer.sv | 140 ++++++++++++++
 tb/tb_instr_mem_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sequencer.sv
// rtl/instr_mem_sequencer.sv - multicycle fetch/decode/data/commit sequencer over one shared memory port
module instr_mem_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_step,
    input  logic              i_dm_ren,
    input  logic              i_dm_wen,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wd,
    output logic [DATA_W-1:0] o_dm_rd,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wd,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic              o_err
);

    localparam int                WD_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(MAX_WAIT - 1);
    localparam logic [DATA_W-1:0] NOP     = DATA_W'(32'h0000_0013);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DATA,
        S_COMMIT,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   dm_rd_q, dm_rd_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            instr_q <= NOP;
            dm_rd_q <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            dm_rd_q <= dm_rd_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        dm_rd_d    = dm_rd_q;
        wdog_d     = wdog_q;
        o_mem_req  = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_mem_wd   = '0;
        o_step     = 1'b0;
        o_busy     = 1'b1;
        o_err      = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_en) begin
                    state_d = S_FETCH;
                    wdog_d  = '0;
                end
            end
            S_FETCH: begin
                o_mem_req  = 1'b1;
                o_mem_addr = i_pc;
                if (i_mem_ack) begin
                    instr_d = i_mem_rdata;
                    state_d = S_DECODE;
                end else if (wdog_q == WD_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_DECODE: begin
                if (i_dm_ren || i_dm_wen) begin
                    state_d = S_DATA;
                    wdog_d  = '0;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_DATA: begin
                o_mem_req  = 1'b1;
                o_mem_addr = i_dm_addr;
                o_mem_we   = i_dm_wen;
                o_mem_wd   = i_dm_wd;
                if (i_mem_ack) begin
                    // a simultaneous ren+wen is a store, so the load register keeps its value
                    if (i_dm_ren && !i_dm_wen) begin
                        dm_rd_d = i_mem_rdata;
                    end
                    state_d = S_COMMIT;
                end else if (wdog_q == WD_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_COMMIT: begin
                o_step = 1'b1;
                if (i_en) begin
                    state_d = S_FETCH;
                    wdog_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                o_busy = 1'b0;
                o_err  = 1'b1;
            end
            default: begin
                o_busy  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_instr = instr_q;
    assign o_dm_rd = dm_rd_q;

endmodule

// File: tb/tb_instr_mem_sequencer.sv
// tb/tb_instr_mem_sequencer.sv - scoreboard bench for instr_mem_sequencer
module tb_instr_mem_sequencer;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
    } txn_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [31:0] pc = '0;
    logic        dm_ren = 1'b0;
    logic        dm_wen = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wd = '0;
    logic [31:0] instr, dm_rd, mem_addr, mem_wd, mem_rdata;
    logic        step, mem_req, mem_we, mem_ack, busy, err;

    logic [31:0] mem [0:255];
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          slow_wait = 0;
    int          wait_cnt = 0;
    logic        mem_dead = 1'b0;

    txn_t exp_q[$];
    txn_t obs_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    instr_mem_sequencer #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_pc(pc),
        .o_instr(instr), .o_step(step),
        .i_dm_ren(dm_ren), .i_dm_wen(dm_wen), .i_dm_addr(dm_addr), .i_dm_wd(dm_wd),
        .o_dm_rd(dm_rd),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wd(mem_wd),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;

    // memory model: the slow address acks after slow_wait waiting cycles, others at once
    assign mem_ack   = mem_req && !mem_dead && (mem_addr != slow_addr || wait_cnt >= slow_wait);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (mem_req && mem_we && mem_ack) mem[mem_addr[9:2]] <= mem_wd;
    end

    always @(negedge clk) begin
        if (mem_req && mem_ack) obs_q.push_back('{addr: mem_addr, we: mem_we, wd: mem_wd});
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (instr !== 32'h0000_0013) $display("FAIL reset_instr: got %h required 00000013", instr); else pass_cnt++;
        total_cnt++;
        if ({dm_rd, mem_req, step, busy, err, mem_addr, mem_we, mem_wd} !== '0)
            $display("FAIL reset_outputs: got rd=%h req=%b step=%b busy=%b err=%b addr=%h required all 0",
                     dm_rd, mem_req, step, busy, err, mem_addr);
        else pass_cnt++;
        rstn = 1'b1;
        @(negedge clk);
        obs_q.delete();
    endtask

    task automatic test_fetch_nonmem();
        int   steps = 0;
        int   first_step = 0;
        txn_t e, o;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0000_0013;
        pc = 0; dm_ren = 0; dm_wen = 0;
        en = 1'b1;
        exp_q.push_back('{addr: 32'h0, we: 1'b0, wd: 32'h0});
        exp_q.push_back('{addr: 32'h4, we: 1'b0, wd: 32'h0});
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (step) begin steps++; if (first_step == 0) first_step = c; end
            if (c == 2) begin
                total_cnt++;
                if (instr !== 32'h0050_0093) $display("FAIL fetch_instr: got %h required 00500093", instr); else pass_cnt++;
            end
            if (c == 3) pc = 32'h4;
            if (c == 4) begin
                total_cnt++;
                if (!(mem_req && mem_addr == 32'h4))
                    $display("FAIL fetch_next_pc: got req=%b addr=%h required req=1 addr=00000004", mem_req, mem_addr);
                else pass_cnt++;
                en = 1'b0;
            end
        end
        total_cnt++;
        if (first_step !== 3 || steps !== 2)
            $display("FAIL fetch_step: got first=%0d count=%0d required first=3 count=2", first_step, steps);
        else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) $display("FAIL fetch_txn: got none required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL fetch_txn: got %h required %h", o, e); else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL fetch_extra: got %0d extra requests required 0", obs_q.size()); else pass_cnt++;
        obs_q.delete();
    endtask

    task automatic test_load();
        int   first_step = 0;
        int   hold_bad = 0;
        txn_t e, o;
        mem[2] = 32'h1000_2083;
        mem[64] = 32'hDEAD_BEEF;
        slow_addr = 32'h100; slow_wait = 2;
        pc = 32'h8; dm_ren = 1; dm_wen = 0; dm_addr = 32'h100; dm_wd = 0;
        en = 1'b1;
        exp_q.push_back('{addr: 32'h8, we: 1'b0, wd: 32'h0});
        exp_q.push_back('{addr: 32'h100, we: 1'b0, wd: 32'h0});
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) en = 1'b0;
            if (step && first_step == 0) first_step = c;
            if (c >= 3 && c <= 5 && !(mem_req && mem_addr == 32'h100 && !mem_we)) hold_bad++;
            if (c == 5) begin
                total_cnt++;
                if (dm_rd !== 32'h0) $display("FAIL load_rd_early: got %h required 00000000", dm_rd); else pass_cnt++;
            end
        end
        total_cnt++;
        if (hold_bad != 0) $display("FAIL load_hold: got %0d bad DATA cycles required 0", hold_bad); else pass_cnt++;
        total_cnt++;
        if (first_step !== 6) $display("FAIL load_step: got cycle %0d required 6", first_step); else pass_cnt++;
        total_cnt++;
        if (dm_rd !== 32'hDEAD_BEEF) $display("FAIL load_rd: got %h required deadbeef", dm_rd); else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) $display("FAIL load_txn: got none required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL load_txn: got %h required %h", o, e); else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL load_extra: got %0d extra requests required 0", obs_q.size()); else pass_cnt++;
        obs_q.delete();
        slow_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_store();
        int   first_step = 0;
        txn_t e, o;
        mem[3] = 32'h0010_2023;
        pc = 32'hC; dm_ren = 1; dm_wen = 1; dm_addr = 32'h40; dm_wd = 32'h1234_5678;
        en = 1'b1;
        exp_q.push_back('{addr: 32'hC, we: 1'b0, wd: 32'h0});
        exp_q.push_back('{addr: 32'h40, we: 1'b1, wd: 32'h1234_5678});
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) en = 1'b0;
            if (step && first_step == 0) first_step = c;
        end
        total_cnt++;
        if (first_step !== 4) $display("FAIL store_step: got cycle %0d required 4", first_step); else pass_cnt++;
        total_cnt++;
        if (dm_rd !== 32'hDEAD_BEEF) $display("FAIL store_rd: got %h required deadbeef", dm_rd); else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) $display("FAIL store_txn: got none required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL store_txn: got %h required %h", o, e); else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL store_extra: got %0d extra requests required 0", obs_q.size()); else pass_cnt++;
        obs_q.delete();
        dm_ren = 0; dm_wen = 0; dm_wd = 0;
    endtask

    task automatic test_en_drop();
        int   first_step = 0;
        int   idle_bad = 0;
        txn_t e, o;
        mem[4] = 32'h0000_0013;
        pc = 32'h10; dm_ren = 0; dm_wen = 0;
        en = 1'b1;
        exp_q.push_back('{addr: 32'h10, we: 1'b0, wd: 32'h0});
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) en = 1'b0;
            if (step && first_step == 0) first_step = c;
            if (c >= 4 && (busy || mem_req || step)) idle_bad++;
        end
        total_cnt++;
        if (first_step !== 3) $display("FAIL endrop_step: got cycle %0d required 3", first_step); else pass_cnt++;
        total_cnt++;
        if (idle_bad != 0) $display("FAIL endrop_idle: got %0d active cycles required 0", idle_bad); else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) $display("FAIL endrop_txn: got none required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL endrop_txn: got %h required %h", o, e); else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL endrop_extra: got %0d extra requests required 0", obs_q.size()); else pass_cnt++;
        obs_q.delete();
    endtask

    task automatic test_reset_mid_data();
        int   idle_bad = 0;
        txn_t e, o;
        mem[5] = 32'h0800_2083;
        slow_addr = 32'h80; slow_wait = 10;
        pc = 32'h14; dm_ren = 1; dm_wen = 0; dm_addr = 32'h80;
        en = 1'b1;
        exp_q.push_back('{addr: 32'h14, we: 1'b0, wd: 32'h0});
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) en = 1'b0;
        end
        total_cnt++;
        if (!(mem_req && mem_addr == 32'h80)) $display("FAIL rstdata_wait: got req=%b addr=%h required req=1 addr=00000080", mem_req, mem_addr); else pass_cnt++;
        #1 rstn = 1'b0;
        #1;
        total_cnt++;
        if ({dm_rd, mem_req, step, busy, err, mem_addr, mem_we, mem_wd} !== '0 || instr !== 32'h0000_0013)
            $display("FAIL rstdata_outputs: got instr=%h rd=%h req=%b busy=%b addr=%h required instr=00000013 rest 0",
                     instr, dm_rd, mem_req, busy, mem_addr);
        else pass_cnt++;
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (busy || mem_req || step) idle_bad++;
        end
        total_cnt++;
        if (idle_bad != 0) $display("FAIL rstdata_idle: got %0d active cycles required 0", idle_bad); else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) $display("FAIL rstdata_txn: got none required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL rstdata_txn: got %h required %h", o, e); else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL rstdata_extra: got %0d extra requests required 0", obs_q.size()); else pass_cnt++;
        obs_q.delete();
        slow_addr = 32'hFFFF_FFFF; dm_ren = 0;
    endtask

    task automatic test_watchdog();
        int steps = 0;
        int err_bad = 0;
        mem_dead = 1'b1;
        pc = 32'h18;
        en = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (step) steps++;
            if (c == 4) begin
                total_cnt++;
                if (!(mem_req && !err)) $display("FAIL wdog_last_wait: got req=%b err=%b required req=1 err=0", mem_req, err); else pass_cnt++;
            end
            if (c >= 5 && !(err && !mem_req && !busy)) err_bad++;
        end
        total_cnt++;
        if (err_bad != 0) $display("FAIL wdog_err: got %0d cycles outside ERR required 0", err_bad); else pass_cnt++;
        total_cnt++;
        if (steps != 0) $display("FAIL wdog_step: got %0d steps required 0", steps); else pass_cnt++;
        en = 1'b0;
        mem_dead = 1'b0;
        rstn = 1'b0;
        #1;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL wdog_clear: got err=%b required 0", err); else pass_cnt++;
        @(negedge clk);
        rstn = 1'b1;
        obs_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_fetch_nonmem();
        test_load();
        test_store();
        test_en_drop();
        test_reset_mid_data();
        test_watchdog();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
